// File: rtl/button_controller.sv
// Push-button front end for the digital clock: synchronises and debounces the
// Set, Alarm, Button0 and Button1 pins, produces one-cycle press strobes and
// auto-repeats Button0/Button1 while they are held.
module button_controller #(
   parameter int CLKS_PER_MS      = 1,
   parameter int DEBOUNCE_MS      = 20,
   parameter int REPEAT_DELAY_MS  = 500,
   parameter int REPEAT_PERIOD_MS = 100
) (
   input  logic mclk,
   input  logic rst,
   input  logic pSetButton,
   input  logic pAlarmButton,
   input  logic pButton0,
   input  logic pButton1,
   output logic setPress,
   output logic alarmPress,
   output logic btn0Press,
   output logic btn1Press,
   output logic setLevel,
   output logic alarmLevel,
   output logic btn0Level,
   output logic btn1Level
);

   localparam int N    = DEBOUNCE_MS * CLKS_PER_MS;
   localparam int D    = REPEAT_DELAY_MS * CLKS_PER_MS;
   localparam int P    = REPEAT_PERIOD_MS * CLKS_PER_MS;
   localparam int MAXC = (N > D) ? ((N > P) ? N : P) : ((D > P) ? D : P);
   localparam int W    = $clog2(MAXC) + 1;

   localparam logic [W-1:0] LAST_N = W'(N - 1);
   localparam logic [W-1:0] LAST_D = W'(D - 1);
   localparam logic [W-1:0] LAST_P = W'(P - 1);

   // Channel order: 0 = Set, 1 = Alarm, 2 = Button0, 3 = Button1
   logic [3:0] pins;
   logic [3:0] sync1;
   logic [3:0] sync2;
   logic [3:0] level;
   logic [3:0] press;

   assign pins = {pButton1, pButton0, pAlarmButton, pSetButton};

   // Two-flop synchroniser for every raw pin; only sync2 is used further on
   always_ff @(posedge mclk or negedge rst) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= pins;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_chan
      logic [W-1:0] cnt;
      logic         level_r;
      logic         press_r;
      logic         accept;
      logic         rise;

      // Accept a new level once the mismatch has persisted for N samples
      always_comb begin
         accept = (sync2[i] != level_r) && (cnt == LAST_N);
         rise   = accept && sync2[i];
      end

      // Debounce counter restarts whenever the synchronised pin agrees with level
      always_ff @(posedge mclk or negedge rst) begin
         if (!rst) begin
            cnt     <= '0;
            level_r <= 1'b0;
         end else if (sync2[i] == level_r) begin
            cnt <= '0;
         end else if (accept) begin
            level_r <= sync2[i];
            cnt     <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end

      if (i >= 2) begin : g_repeat
         logic [W-1:0] hcnt;
         logic         rpt;
         logic         level_next;
         logic         held;
         logic         fire;

         // Repeat only while level was high and stays high this edge, so a
         // release never sneaks out one last strobe
         always_comb begin
            level_next = accept ? sync2[i] : level_r;
            held       = level_r && level_next;
            fire       = held && (rpt ? (hcnt == LAST_P) : (hcnt == LAST_D));
         end

         // Hold counter: first lap measures the delay, later laps the period
         always_ff @(posedge mclk or negedge rst) begin
            if (!rst) begin
               hcnt <= '0;
               rpt  <= 1'b0;
            end else if (!held) begin
               hcnt <= '0;
               rpt  <= 1'b0;
            end else if (fire) begin
               hcnt <= '0;
               rpt  <= 1'b1;
            end else begin
               hcnt <= hcnt + 1'b1;
            end
         end

         // Strobe on the accepted press and on every repeat
         always_ff @(posedge mclk or negedge rst) begin
            if (!rst) press_r <= 1'b0;
            else      press_r <= rise || fire;
         end
      end else begin : g_single
         // Strobe only on the accepted press
         always_ff @(posedge mclk or negedge rst) begin
            if (!rst) press_r <= 1'b0;
            else      press_r <= rise;
         end
      end

      assign level[i] = level_r;
      assign press[i] = press_r;
   end

   assign setPress   = press[0];
   assign alarmPress = press[1];
   assign btn0Press  = press[2];
   assign btn1Press  = press[3];
   assign setLevel   = level[0];
   assign alarmLevel = level[1];
   assign btn0Level  = level[2];
   assign btn1Level  = level[3];

endmodule

// File: tb/tb_button_controller.sv
// Directed bench for button_controller with default timing (N=20, D=500, P=100).
module tb_button_controller;

   localparam int N = 20;
   localparam int D = 500;
   localparam int P = 100;

   logic       mclk;
   logic       rst;
   logic [3:0] pins_drv;
   logic       setPress, alarmPress, btn0Press, btn1Press;
   logic       setLevel, alarmLevel, btn0Level, btn1Level;
   logic [3:0] press_vec;
   logic [3:0] level_vec;

   int checks;
   int failures;
   int counts[4];
   logic [3:0] level_at_end;

   typedef struct {
      logic [3:0] pins;
      int         hold;
      int         c0;
      int         c1;
      int         c2;
      int         c3;
      logic [3:0] exp_level;
   } vec_t;

   vec_t vecs[9];

   button_controller dut (
      .mclk(mclk),
      .rst(rst),
      .pSetButton(pins_drv[0]),
      .pAlarmButton(pins_drv[1]),
      .pButton0(pins_drv[2]),
      .pButton1(pins_drv[3]),
      .setPress(setPress),
      .alarmPress(alarmPress),
      .btn0Press(btn0Press),
      .btn1Press(btn1Press),
      .setLevel(setLevel),
      .alarmLevel(alarmLevel),
      .btn0Level(btn0Level),
      .btn1Level(btn1Level)
   );

   assign press_vec = {btn1Press, btn0Press, alarmPress, setPress};
   assign level_vec = {btn1Level, btn0Level, alarmLevel, setLevel};

   // Free-running 100 MHz clock
   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   // Compare one observed value against the bench's own expectation
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Step one cycle and sample outputs 1 time unit after the rising edge
   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   // Drive a pin pattern for hold cycles, then release and let the levels
   // settle, counting every strobe per channel along the way
   task automatic applyStimulus(input logic [3:0] p, input int hold);
      for (int c = 0; c < 4; c++) counts[c] = 0;
      pins_drv = p;
      for (int k = 0; k < hold; k++) begin
         step();
         for (int c = 0; c < 4; c++) if (press_vec[c]) counts[c]++;
      end
      level_at_end = level_vec;
      pins_drv = 4'b0000;
      for (int k = 0; k < N + 5; k++) begin
         step();
         for (int c = 0; c < 4; c++) if (press_vec[c]) counts[c]++;
      end
   endtask

   // Count cycles until the given strobe appears; -1 if the bound expires
   task automatic waitPress(input int ch, input int limit, output int n);
      n = -1;
      for (int k = 1; k <= limit; k++) begin
         step();
         if (press_vec[ch]) begin
            n = k;
            break;
         end
      end
   endtask

   initial begin
      int n;
      int extra;

      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      pins_drv = 4'b0000;

      // Vector table: pins, hold cycles, expected strobe counts, levels at end of hold
      vecs[0] = '{4'b0001,   30, 1, 0, 0, 0, 4'b0001};
      vecs[1] = '{4'b0010,   10, 0, 0, 0, 0, 4'b0000};
      vecs[2] = '{4'b0100, 1000, 0, 0, 6, 0, 4'b0100};
      vecs[3] = '{4'b0001, 1000, 1, 0, 0, 0, 4'b0001};
      vecs[4] = '{4'b1100,   30, 0, 0, 1, 1, 4'b1100};
      vecs[5] = '{4'b1111,  600, 1, 1, 2, 2, 4'b1111};
      vecs[6] = '{4'b1000,   19, 0, 0, 0, 0, 4'b0000};
      vecs[7] = '{4'b0010,   20, 0, 1, 0, 0, 4'b0000};
      vecs[8] = '{4'b1000, 1000, 0, 0, 0, 6, 4'b1000};

      // Reset with idle pins, then with a pin high during reset
      repeat (3) step();
      checkOutput("reset_press", int'(press_vec), 0);
      checkOutput("reset_level", int'(level_vec), 0);
      pins_drv = 4'b0001;
      repeat (30) step();
      checkOutput("reset_pin_high_press", int'(press_vec), 0);
      checkOutput("reset_pin_high_level", int'(level_vec), 0);
      rst = 1'b1;
      waitPress(0, 100, n);
      checkOutput("post_reset_press_latency", n, N + 2);
      pins_drv = 4'b0000;
      repeat (40) step();

      // Table-driven vectors
      for (int v = 0; v < 9; v++) begin
         applyStimulus(vecs[v].pins, vecs[v].hold);
         checkOutput($sformatf("v%0d_set_count", v),   counts[0], vecs[v].c0);
         checkOutput($sformatf("v%0d_alarm_count", v), counts[1], vecs[v].c1);
         checkOutput($sformatf("v%0d_btn0_count", v),  counts[2], vecs[v].c2);
         checkOutput($sformatf("v%0d_btn1_count", v),  counts[3], vecs[v].c3);
         checkOutput($sformatf("v%0d_hold_level", v),  int'(level_at_end), int'(vecs[v].exp_level));
         checkOutput($sformatf("v%0d_idle_level", v),  int'(level_vec), 0);
         repeat (10) step();
      end

      // Exact press latency, one-cycle width and silent release on Set
      pins_drv = 4'b0001;
      waitPress(0, 100, n);
      checkOutput("set_press_latency", n, N + 2);
      checkOutput("set_level_at_press", int'(setLevel), 1);
      step();
      checkOutput("set_press_width", int'(setPress), 0);
      repeat (8) step();
      pins_drv = 4'b0000;
      n = -1;
      extra = 0;
      for (int k = 1; k <= 100; k++) begin
         step();
         if (setPress) extra++;
         if (!setLevel) begin
            n = k;
            break;
         end
      end
      checkOutput("set_release_latency", n, N + 2);
      checkOutput("set_release_no_strobe", extra, 0);
      repeat (10) step();

      // Simultaneous Button0/Button1 press strobes on the same cycle
      pins_drv = 4'b1100;
      n = -1;
      for (int k = 1; k <= 100; k++) begin
         step();
         if (btn0Press || btn1Press) begin
            n = k;
            break;
         end
      end
      checkOutput("simul_latency", n, N + 2);
      checkOutput("simul_both", int'({btn1Press, btn0Press}), 3);
      pins_drv = 4'b0000;
      repeat (40) step();

      // Reset in the middle of a Button1 hold, pin still high afterwards
      pins_drv = 4'b1000;
      waitPress(3, 100, n);
      checkOutput("hold_b1_first_press", n, N + 2);
      repeat (300) step();
      rst = 1'b0;
      #1;
      checkOutput("midhold_async_level", int'(btn1Level), 0);
      repeat (5) step();
      checkOutput("midhold_reset_press", int'(press_vec), 0);
      checkOutput("midhold_reset_level", int'(level_vec), 0);
      rst = 1'b1;
      waitPress(3, 100, n);
      checkOutput("midhold_fresh_press", n, N + 2);
      waitPress(3, D + 50, n);
      checkOutput("midhold_first_repeat", n, D);
      waitPress(3, P + 50, n);
      checkOutput("midhold_second_repeat", n, P);
      pins_drv = 4'b0000;
      repeat (40) step();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   // Hard time limit so a stuck run still ends with a report
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: got running, expected finished");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
